// File: rtl/datapath_controller_pkg.sv
// Shared constants for the datapath controller: state encoding, opcode/op values,
// ALU operation codes and instruction field bit positions.
package datapath_controller_pkg;

    localparam int INSTR_W = 16;
    localparam int RADDR_W = 3;

    typedef enum logic [2:0] {
        WAIT    = 3'd0,
        DECODE  = 3'd1,
        GET_A   = 3'd2,
        GET_B   = 3'd3,
        COMPUTE = 3'd4,
        WB_REG  = 3'd5,
        WB_IMM  = 3'd6,
        TRAP    = 3'd7
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;

endpackage

// File: rtl/datapath_controller_decode.sv
// Combinational instruction field split and classification for the controller FSM.
module datapath_controller_decode
    import datapath_controller_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [1:0]         op,
    output logic [RADDR_W-1:0] rn,
    output logic [RADDR_W-1:0] rd,
    output logic [RADDR_W-1:0] rm,
    output logic [1:0]         sh,
    output logic               is_legal,
    output logic               is_mov_imm,
    output logic               is_mov_reg,
    output logic               is_cmp,
    output logic               needs_a
);

    logic [2:0] opcode;
    logic       is_alu;

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign op     = instr[OP_MSB:OP_LSB];
    assign rn     = instr[RN_MSB:RN_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign sh     = instr[SH_MSB:SH_LSB];
    assign rm     = instr[RM_MSB:RM_LSB];

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;
    assign is_cmp     = is_alu && (op == ALU_SUB);
    // MVN reads only Rm, so only ADD/CMP/AND visit GET_A
    assign needs_a    = is_alu && (op != ALU_NOTB);

endmodule

// File: rtl/datapath_controller.sv
// Multicycle controller sequencing register file and ALU strobes, one instruction per start.
// Optional: define CTRL_ILLEGAL_TRAP_EN to trap (sticky err) on illegal instructions.
module datapath_controller
    import datapath_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic [RADDR_W-1:0] readnum,
    output logic [RADDR_W-1:0] writenum,
    output logic               write,
    output logic               vsel,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic [1:0]         shift,
    output logic [1:0]         ALUop,
    output logic               loadc,
    output logic               loads,
    output logic               err
);

    state_t state, state_nxt;

    logic [1:0]         op;
    logic [RADDR_W-1:0] rn, rd, rm;
    logic [1:0]         sh;
    logic               is_legal, is_mov_imm, is_mov_reg, is_cmp, needs_a;

    datapath_controller_decode u_decode (
        .instr      (instr),
        .op         (op),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .is_legal   (is_legal),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_cmp     (is_cmp),
        .needs_a    (needs_a)
    );

    // NOTE: state flops use non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT;
        else          state <= state_nxt;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (s) state_nxt = DECODE;
            DECODE: begin
                if (is_mov_imm)    state_nxt = WB_IMM;
                else if (needs_a)  state_nxt = GET_A;
                else if (is_legal) state_nxt = GET_B;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else               state_nxt = TRAP;
`else
                else               state_nxt = WAIT;
`endif
            end
            GET_A:   state_nxt = GET_B;
            GET_B:   state_nxt = COMPUTE;
            COMPUTE: state_nxt = is_cmp ? WAIT : WB_REG;
            WB_REG:  state_nxt = WAIT;
            WB_IMM:  state_nxt = WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:    state_nxt = TRAP;
`endif
            default: state_nxt = WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        loadc    = 1'b0;
        loads    = 1'b0;
        err      = 1'b0;
        case (state)
            WAIT:  w = 1'b1;
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            COMPUTE: begin
                shift = sh;
                asel  = is_mov_reg || (op == ALU_NOTB);
                ALUop = is_mov_reg ? ALU_ADD : op;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            WB_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            WB_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:  err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
